// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises and debounces encoder A/B/index,
// decodes Gray-code steps at x4 resolution and emits one-cycle counter
// commands (00 hold, 01 inc, 10 dec, 11 reset).
module quad_step_decoder #(
  parameter int DB_CYCLES = 8,
  parameter int DB_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enc_idx,
  input  logic       err_clr,
  output logic [1:0] control,
  output logic       dir,
  output logic       err,
  output logic       dbg_state
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int              IW        = DB_W + 1;
  localparam logic [IW-1:0]   INIT_LAST = IW'(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DB_CYCLES);

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_RST  = 2'b11;

  // Channel order in all 3-bit vectors: bit0 = A, bit1 = B, bit2 = index.
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            acc_q, acc_d;
  logic [2:0]            prev_q, prev_d;
  logic [2:0][DB_W-1:0]  cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic [IW-1:0]         init_cnt_q, init_cnt_d;
  logic [1:0]            control_q, control_d;
  logic                  dir_q, dir_d;
  logic                  err_q, err_d;

  logic [1:0] ab_prev, ab_cur;
  logic       step_fwd, step_rev, step_ill, idx_edge;

  // Two-flop synchronisers on the asynchronous encoder inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {enc_idx, enc_b, enc_a};
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce; during INIT the accepted values track the synced
  // values directly so RUN starts from the real encoder position.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (state_q == ST_INIT) begin
        acc_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else if (sync2_q[i] == acc_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        acc_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Step classification from previous vs current accepted {A,B}.
  always_comb begin
    ab_prev  = {prev_q[0], prev_q[1]};
    ab_cur   = {acc_q[0], acc_q[1]};
    step_fwd = ((ab_prev == 2'b00) && (ab_cur == 2'b01)) ||
               ((ab_prev == 2'b01) && (ab_cur == 2'b11)) ||
               ((ab_prev == 2'b11) && (ab_cur == 2'b10)) ||
               ((ab_prev == 2'b10) && (ab_cur == 2'b00));
    step_rev = ((ab_prev == 2'b01) && (ab_cur == 2'b00)) ||
               ((ab_prev == 2'b11) && (ab_cur == 2'b01)) ||
               ((ab_prev == 2'b10) && (ab_cur == 2'b11)) ||
               ((ab_prev == 2'b00) && (ab_cur == 2'b10));
    step_ill = ((ab_prev ^ ab_cur) == 2'b11);
    idx_edge = acc_q[2] & ~prev_q[2];
  end

  // FSM next state and registered-output next values. The previous-state
  // register always follows the accepted values, so tracking continues
  // while en is low or after an illegal jump.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = acc_q;
    control_d  = CMD_HOLD;
    dir_d      = dir_q;
    err_d      = err_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (step_fwd) dir_d = 1'b1;
        else if (step_rev) dir_d = 1'b0;
        // Setting wins over a simultaneous clear.
        if (step_ill) err_d = 1'b1;
        if (en) begin
          if (idx_edge) control_d = CMD_RST;
          else if (step_fwd) control_d = CMD_INC;
          else if (step_rev) control_d = CMD_DEC;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, debounce and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      acc_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      control_q  <= CMD_HOLD;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      acc_q      <= acc_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      control_q  <= control_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign control   = control_q;
  assign dir       = dir_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with DB_CYCLES = 4: steps, glitch,
// illegal jump, index collision, enable gating and mid-run reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_quad_step_decoder;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;     // edge-to-pulse latency in clocks
  localparam int WIN = 10;         // clocks each input level is held

  logic       clk, rst, en, enc_a, enc_b, enc_idx, err_clr;
  logic [1:0] control;
  logic       dir, err, dbg_state;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  quad_step_decoder #(.DB_CYCLES(DB), .DB_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .enc_a(enc_a), .enc_b(enc_b),
    .enc_idx(enc_idx), .err_clr(err_clr), .control(control), .dir(dir),
    .err(err), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive new levels at a falling edge, then watch n clocks. Returns the code
  // seen LAT clocks after the first sampling edge, and the count of non-hold
  // codes seen anywhere in the window.
  task automatic drive_watch(input logic a, input logic b, input logic idx,
                             input int n, output logic [1:0] code_lat,
                             output int nz);
    enc_a = a; enc_b = b; enc_idx = idx;
    code_lat = 2'b00;
    nz = 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); @(negedge clk);
      if (control !== 2'b00) nz++;
      if (c == LAT + 1) code_lat = control;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_idx = 1'b0;
    err_clr = 1'b0;
    idle(3);
    checks++; if (control !== 2'b00) begin errors++; $display("FAIL reset_control got=%b want=00", control); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b want=0", dir); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got=%b want=0", dbg_state); end
    rst = 1'b0;
    idle(2);
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL init_hold_state got=%b want=0", dbg_state); end
    idle(8);
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL init_done_state got=%b want=1", dbg_state); end
    checks++; if (control !== 2'b00) begin errors++; $display("FAIL init_done_control got=%b want=00", control); end
  endtask

  task automatic test_forward();
    logic [1:0] code, exp;
    int nz;
    logic [1:0] seq_ab [4];
    seq_ab[0] = 2'b01; seq_ab[1] = 2'b11; seq_ab[2] = 2'b10; seq_ab[3] = 2'b00;
    for (int i = 0; i < 4; i++) exp_q.push_back(2'b01);
    for (int i = 0; i < 4; i++) begin
      drive_watch(seq_ab[i][1], seq_ab[i][0], 1'b0, WIN, code, nz);
      exp = exp_q.pop_front();
      checks++; if (code !== exp) begin errors++; $display("FAIL fwd_step%0d_code got=%b want=%b", i, code, exp); end
      checks++; if (nz !== 1) begin errors++; $display("FAIL fwd_step%0d_width got=%0d want=1", i, nz); end
    end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir got=%b want=1", dir); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fwd_err got=%b want=0", err); end
  endtask

  task automatic test_reverse_glitch();
    logic [1:0] code;
    int nz;
    logic [1:0] seq_ab [3];
    seq_ab[0] = 2'b10; seq_ab[1] = 2'b11; seq_ab[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      drive_watch(seq_ab[i][1], seq_ab[i][0], 1'b0, WIN, code, nz);
      checks++; if (code !== 2'b10) begin errors++; $display("FAIL rev_step%0d_code got=%b want=10", i, code); end
      checks++; if (nz !== 1) begin errors++; $display("FAIL rev_step%0d_width got=%0d want=1", i, nz); end
    end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rev_dir got=%b want=0", dir); end
    // 3-clock glitch on A while AB = 01
    drive_watch(1'b1, 1'b1, 1'b0, 3, code, nz);
    drive_watch(1'b0, 1'b1, 1'b0, 12, code, nz);
    checks++; if (nz !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d want=0", nz); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL glitch_dir got=%b want=0", dir); end
    // Accepted state must still be 01: 01 -> 00 is a reverse step.
    drive_watch(1'b0, 1'b0, 1'b0, WIN, code, nz);
    checks++; if (code !== 2'b10) begin errors++; $display("FAIL post_glitch_code got=%b want=10", code); end
    checks++; if (nz !== 1) begin errors++; $display("FAIL post_glitch_width got=%0d want=1", nz); end
  endtask

  task automatic test_illegal();
    logic [1:0] code;
    int nz;
    drive_watch(1'b1, 1'b1, 1'b0, WIN, code, nz);
    checks++; if (nz !== 0) begin errors++; $display("FAIL illegal_pulses got=%0d want=0", nz); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b want=1", err); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL illegal_dir got=%b want=0", dir); end
    idle(5);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%b want=1", err); end
    drive_watch(1'b1, 1'b0, 1'b0, WIN, code, nz);
    checks++; if (code !== 2'b01) begin errors++; $display("FAIL after_illegal_code got=%b want=01", code); end
    checks++; if (nz !== 1) begin errors++; $display("FAIL after_illegal_width got=%0d want=1", nz); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL after_illegal_err got=%b want=1", err); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr got=%b want=0", err); end
  endtask

  task automatic test_index_collision();
    logic [1:0] code;
    int nz;
    // AB 10 -> 11 -> 01 (reverse), leaving dir = 0
    drive_watch(1'b1, 1'b1, 1'b0, WIN, code, nz);
    drive_watch(1'b0, 1'b1, 1'b0, WIN, code, nz);
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL idx_pre_dir got=%b want=0", dir); end
    // A rises (01 -> 11 forward) together with index
    drive_watch(1'b1, 1'b1, 1'b1, WIN, code, nz);
    checks++; if (code !== 2'b11) begin errors++; $display("FAIL idx_code got=%b want=11", code); end
    checks++; if (nz !== 1) begin errors++; $display("FAIL idx_width got=%0d want=1", nz); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL idx_dir got=%b want=1", dir); end
    drive_watch(1'b1, 1'b1, 1'b0, WIN, code, nz);
    checks++; if (nz !== 0) begin errors++; $display("FAIL idx_fall_pulses got=%0d want=0", nz); end
  endtask

  task automatic test_enable_and_reset();
    logic [1:0] code;
    int nz;
    // 11 -> 01 reverse so dir starts at 0
    drive_watch(1'b0, 1'b1, 1'b0, WIN, code, nz);
    checks++; if (code !== 2'b10) begin errors++; $display("FAIL en_pre_code got=%b want=10", code); end
    en = 1'b0;
    drive_watch(1'b1, 1'b1, 1'b0, WIN, code, nz);
    checks++; if (nz !== 0) begin errors++; $display("FAIL en_off_step1 got=%0d want=0", nz); end
    drive_watch(1'b1, 1'b0, 1'b0, WIN, code, nz);
    checks++; if (nz !== 0) begin errors++; $display("FAIL en_off_step2 got=%0d want=0", nz); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL en_off_dir got=%b want=1", dir); end
    en = 1'b1;
    drive_watch(1'b1, 1'b0, 1'b0, WIN, code, nz);
    checks++; if (nz !== 0) begin errors++; $display("FAIL reenable_spurious got=%0d want=0", nz); end
    drive_watch(1'b0, 1'b0, 1'b0, WIN, code, nz);
    checks++; if (code !== 2'b01) begin errors++; $display("FAIL reenable_step got=%b want=01", code); end
    // 00 -> 01 -> 11, forward, back to back in consecutive sampling windows
    drive_watch(1'b0, 1'b1, 1'b0, WIN, code, nz);
    drive_watch(1'b1, 1'b1, 1'b0, WIN, code, nz);
    checks++; if (code !== 2'b01) begin errors++; $display("FAIL pre_rst_step got=%b want=01", code); end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    drive_watch(1'b1, 1'b1, 1'b0, 20, code, nz);
    checks++; if (nz !== 0) begin errors++; $display("FAIL rst_hold_pulses got=%0d want=0", nz); end
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL rst_run_state got=%b want=1", dbg_state); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rst_dir got=%b want=0", dir); end
    // A still-legal step after reset is decoded normally (11 -> 10 forward)
    drive_watch(1'b1, 1'b0, 1'b0, WIN, code, nz);
    checks++; if (code !== 2'b01) begin errors++; $display("FAIL post_rst_step got=%b want=01", code); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_glitch();
    test_illegal();
    test_index_collision();
    test_enable_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Front end for the up/down counter. Converts a raw quadrature encoder (channels A, B, plus an index pulse) into the counter's 2-bit control code.
- Synchronises and debounces each input, then decodes Gray-code transitions at x4 resolution.
- Emits one-cycle increment, decrement or reset commands, using the same code the counter consumes: 00 hold, 01 increment, 10 decrement, 11 reset.

Parameters:
- DB_CYCLES, 8, consecutive stable clocks a synchronised input must hold before it is accepted (legal range 1..2^DB_W-1).
- DB_W, 4, width of each debounce counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = emit commands; 0 = control forced to 00 while tracking continues
- enc_a  in  1  raw encoder channel A (asynchronous)
- enc_b  in  1  raw encoder channel B (asynchronous)
- enc_idx  in  1  raw index pulse (asynchronous, active-high)
- err_clr  in  1  clears the sticky error flag
- control  out  2  counter command: 00 hold, 01 inc, 10 dec, 11 reset
- dir  out  1  last accepted direction: 1 = forward, 0 = reverse
- err  out  1  sticky illegal-transition flag

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: control = 00, dir = 0, err = 0, FSM in INIT, debounce counters = 0, all synchroniser flops = 0.
- Synchroniser: a 2-flop synchroniser on each of enc_a, enc_b and enc_idx.
- Debounce, per channel:
  - Counter clears whenever the synced value equals the accepted value.
  - Otherwise the counter increments. When it reaches DB_CYCLES, the accepted value takes the synced value and the counter clears.
  - A glitch shorter than DB_CYCLES clocks is never accepted.
- FSM states: INIT and RUN.
- INIT:
  - Entered on reset. Lasts DB_CYCLES+2 clocks.
  - Accepted values load directly from the synced values each clock. The previous-state register loads from the accepted values.
  - control = 00 throughout. No error detection.
  - Transitions to RUN after the last INIT clock.
- RUN, quadrature decode: compare the previous accepted {A,B} with the current accepted {A,B}.
  - Forward sequence is 00→01→11→10→00. A forward step gives control = 01 and dir = 1.
  - Reverse sequence gives control = 10 and dir = 0.
  - Both bits changing in the same cycle is illegal: control = 00, err is set, dir is unchanged, and the previous-state register still updates to the new value.
  - No change gives control = 00.
- Index:
  - A 0→1 edge on the accepted idx gives control = 11 for one cycle.
  - If an index edge and a step are accepted in the same cycle, the index wins: control = 11 and the step is discarded. dir still updates from the step.
- Pulse width: every non-00 code lasts exactly one clock. Back-to-back steps in consecutive cycles are legal and produce consecutive pulses.
- en = 0: control = 00. Decoding, dir, err and previous-state tracking continue, so re-enabling produces no spurious step.
- err: sticky. Cleared by rst or by err_clr. If err_clr and an illegal transition occur in the same cycle, set wins (err = 1).
- Latency: a clean edge on enc_a/enc_b/enc_idx gives its control pulse exactly DB_CYCLES+3 clocks after the first clock edge that samples the new level. The breakdown is 2 sync, DB_CYCLES debounce, 1 output register.
- Reset mid-operation: all in-flight debounce state is discarded and INIT restarts. No command is emitted for input levels present at reset release.

Test Plan:
- Forward rotation, DB_CYCLES=4: drive AB 00→01→11→10→00, each held 10 clocks → four 01 pulses, each 1 clock wide, each 7 clocks after its edge; dir = 1; err = 0.
- Reverse rotation: drive AB 00→10→11→01 → three 10 pulses, dir = 0. Then a glitch on A of 3 clocks (less than DB_CYCLES = 4) → no pulse, accepted state unchanged.
- Illegal jump: AB 00→11 in one step → control stays 00, err = 1 and remains 1. Then a legal 11→10 step → 01 pulse with err still 1. Then assert err_clr → err = 0 next cycle.
- Index collision: idx rising together with a forward A edge (same sampling clock) → a single control = 11 pulse, no 01 pulse, dir = 1.
- Enable gating and reset: en = 0 during two forward steps → control stays 00 and dir = 1. Set en = 1 → no pulse until the next edge. Assert rst for 1 clock with AB = 11 held → no command for DB_CYCLES+2 clocks, and no command after INIT completes.
